scd_column_latch: RTL and testbench
===================================

// Module: scd_column_latch
// PURPOSE
//  Receiver for the serial column-driver link produced by the display sequencer.
//  Samples scd_sdclk/scd_data/scd_load_n/scd_rst_n in the cph1 domain and shifts a
//  WIDTH-bit frame. On load it transfers the frame to parallel column drive outputs.
//  A refresh watchdog blanks the display if frames stop arriving.
// PARAMETERS
//  WIDTH        25     bits per frame (= sequencer send buffer width)
//  SYNC_STAGES  2      synchroniser depth on every scd_* input (>=2)
//  TIMEOUT_CYC  65535  cph1 cycles without a good load before blanking; 0 = watchdog off
// PORTS
//  cph1        in   1      clock; all logic on rising edge
//  pon         in   1      reset, synchronous, active-high
//  scd_sdclk   in   1      serial shift clock (async to cph1)
//  scd_data    in   1      serial data, valid at scd_sdclk rising edge
//  scd_load_n  in   1      frame load strobe, active-low
//  scd_rst_n   in   1      link reset, active-low
//  col_drive   out  WIDTH  latched column drive; bit WIDTH-1 = first bit shifted
//  col_valid   out  1      1 = col_drive holds a good, non-expired frame
//  load_stb    out  1      1-cycle pulse on each accepted load
//  frame_err   out  1      sticky; set on load with bit count != WIDTH
// BEHAVIOUR
//  Reset (pon=1 at a cph1 edge): shift_r=0, bit_cnt=0, col_drive=0, col_valid=0,
//   load_stb=0, frame_err=0, wd_cnt=0, synchroniser flops=idle (sdclk 0, load_n 1,
//   rst_n 1, data 0). pon overrides every other input.
//  Input path: each scd_* input goes through SYNC_STAGES flops, then one history flop.
//   Edge detection compares the last sync stage with the history flop.
//  Latency: a pin transition sampled at edge N takes effect in the registers at edge
//   N+SYNC_STAGES+1. scd_data is delay-matched to scd_sdclk.
//  Shift: on synced scd_sdclk rise: shift_r <= {shift_r[WIDTH-2:0], data}.
//   bit_cnt increments and saturates at WIDTH+1.
//  Load: on synced scd_load_n fall:
//   - bit_cnt==WIDTH: col_drive<=shift_r, col_valid<=1, load_stb<=1, wd_cnt<=0.
//   - else: col_drive unchanged, frame_err<=1, load_stb stays 0.
//   - either case: bit_cnt<=0. shift_r is not cleared.
//  Shift and load on the same edge: shift applies first. The load sees the
//   post-shift shift_r and bit_cnt+1.
//  Link reset: while synced scd_rst_n=0: shift_r=0, bit_cnt=0, col_drive=0,
//   col_valid=0. Sdclk and load edges are ignored. frame_err is not cleared; only pon
//   clears it. Release is level-based, and the next frame starts clean.
//  Watchdog (TIMEOUT_CYC>0): wd_cnt counts cph1 cycles while col_valid=1.
//   On wd_cnt==TIMEOUT_CYC-1: col_drive<=0, col_valid<=0, wd_cnt holds.
//   The next good load restarts it. wd_cnt is ceil(log2(TIMEOUT_CYC+1)) bits.
//  States (derived): IDLE (col_valid=0) -> LIVE on good load.
//   LIVE -> IDLE on watchdog expiry or link reset.
//   A bad load in LIVE stays LIVE with the old frame.
//  Glitch tolerance: a pulse shorter than one cph1 period may be missed.
//   The sender must hold every level for >=2 cph1 cycles.
// TESTING
//  1 Shift 25 bits 1,0,1,0,... then load_n pulse -> col_drive=25'h1555555,
//    col_valid=1, one load_stb pulse SYNC_STAGES+1 edges after load_n falls.
//  2 Shift 24 bits then load -> frame_err=1, col_drive keeps prior frame,
//    no load_stb, bit_cnt=0. Next 25-bit frame loads normally; frame_err stays 1.
//  3 Last sdclk rise coincident with load_n fall (24 prior bits) -> accepted as a
//    25-bit frame containing the final bit; no frame_err.
//  4 scd_rst_n low mid-frame (after 10 bits) for 4 cycles, then a full 25-bit frame
//    -> col_drive=0 and col_valid=0 during the reset, then the new frame latches
//    correctly.
//  5 TIMEOUT_CYC=16, one good load, no further loads -> col_valid falls and
//    col_drive=0 exactly 16 cycles after load_stb.
//  6 pon asserted mid-shift -> all outputs 0 on the next edge, including frame_err.
//    Link edges already in the synchroniser at that edge are discarded.

Source files
------------

// File: rtl/scd_column_latch.sv
// -----------------------------------------------------------------------------
// scd_column_latch
//   Receiver for the serial column-driver link. The four scd_* pins are
//   resynchronised into the cph1 domain, a WIDTH-bit frame is shifted in on
//   each sdclk rise, and a load_n fall transfers a complete frame to the
//   parallel column outputs. A refresh watchdog blanks the columns when good
//   frames stop arriving.
//
// Ports
//   cph1        in   1      clock, all logic on the rising edge
//   pon         in   1      synchronous active-high reset, overrides all inputs
//   scd_sdclk   in   1      serial shift clock (asynchronous to cph1)
//   scd_data    in   1      serial data, valid at the sdclk rising edge
//   scd_load_n  in   1      frame load strobe, active-low
//   scd_rst_n   in   1      link reset, active-low, level-sensitive
//   col_drive   out  WIDTH  latched frame; bit WIDTH-1 is the first bit shifted
//   col_valid   out  1      col_drive holds a good, non-expired frame (LIVE)
//   load_stb    out  1      one-cycle pulse per accepted load
//   frame_err   out  1      sticky; a load arrived with bit count != WIDTH
// -----------------------------------------------------------------------------
module scd_column_latch #(
    parameter int WIDTH       = 25,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             cph1,
    input  logic             pon,
    input  logic             scd_sdclk,
    input  logic             scd_data,
    input  logic             scd_load_n,
    input  logic             scd_rst_n,
    output logic [WIDTH-1:0] col_drive,
    output logic             col_valid,
    output logic             load_stb,
    output logic             frame_err
);

    // bit_cnt must be able to hold WIDTH+1 (saturation value).
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WDOG_ON = (TIMEOUT_CYC > 0);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WDOG_ON ? WD_W'(TIMEOUT_CYC - 1) : '0;

    // Synchroniser chains, history flops and registered edge events.
    logic [SYNC_STAGES-1:0] sdclk_sync, data_sync, load_sync, rst_sync;
    logic sdclk_hist, data_hist, load_hist, rst_hist;
    logic sdclk_rise, load_fall;

    // Main datapath state.
    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] bit_cnt;
    logic [WD_W-1:0]  wd_cnt;

    // Next-state values.
    logic [WIDTH-1:0] shift_nx, col_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [WD_W-1:0]  wd_nx;
    logic             valid_nx, stb_nx, err_nx;

    // Input synchronisers. Edges are registered once more so every pin change
    // reaches the datapath SYNC_STAGES+1 edges after it is first sampled; data
    // and rst_n are taken from their history flops to stay delay-matched.
    always_ff @(posedge cph1) begin
        if (pon) begin
            sdclk_sync <= '0;
            data_sync  <= '0;
            load_sync  <= '1;
            rst_sync   <= '1;
            sdclk_hist <= 1'b0;
            data_hist  <= 1'b0;
            load_hist  <= 1'b1;
            rst_hist   <= 1'b1;
            sdclk_rise <= 1'b0;
            load_fall  <= 1'b0;
        end else begin
            sdclk_sync <= {sdclk_sync[SYNC_STAGES-2:0], scd_sdclk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], scd_data};
            load_sync  <= {load_sync[SYNC_STAGES-2:0], scd_load_n};
            rst_sync   <= {rst_sync[SYNC_STAGES-2:0], scd_rst_n};
            sdclk_hist <= sdclk_sync[SYNC_STAGES-1];
            data_hist  <= data_sync[SYNC_STAGES-1];
            load_hist  <= load_sync[SYNC_STAGES-1];
            rst_hist   <= rst_sync[SYNC_STAGES-1];
            sdclk_rise <= sdclk_sync[SYNC_STAGES-1] & ~sdclk_hist;
            load_fall  <= ~load_sync[SYNC_STAGES-1] & load_hist;
        end
    end

    // Next-state logic: link reset, then shift, watchdog, and load (the load
    // sees the post-shift frame and count so a coincident last bit counts).
    always_comb begin
        shift_nx = shift_r;
        cnt_nx   = bit_cnt;
        col_nx   = col_drive;
        valid_nx = col_valid;
        stb_nx   = 1'b0;
        err_nx   = frame_err;
        wd_nx    = wd_cnt;
        if (!rst_hist) begin
            // frame_err deliberately survives a link reset.
            shift_nx = '0;
            cnt_nx   = '0;
            col_nx   = '0;
            valid_nx = 1'b0;
            wd_nx    = '0;
        end else begin
            if (sdclk_rise) begin
                shift_nx = {shift_r[WIDTH-2:0], data_hist};
                cnt_nx   = (bit_cnt == CNT_SAT) ? bit_cnt : bit_cnt + CNT_W'(1);
            end else begin
                shift_nx = shift_r;
            end

            // Watchdog only runs while LIVE; it parks at WD_LAST after expiry.
            if (WDOG_ON && col_valid) begin
                if (wd_cnt == WD_LAST) begin
                    col_nx   = '0;
                    valid_nx = 1'b0;
                end else begin
                    wd_nx = wd_cnt + WD_W'(1);
                end
            end else begin
                wd_nx = wd_cnt;
            end

            // A good load also overrides a coincident watchdog expiry.
            if (load_fall) begin
                if (cnt_nx == CNT_FULL) begin
                    col_nx   = shift_nx;
                    valid_nx = 1'b1;
                    stb_nx   = 1'b1;
                    wd_nx    = '0;
                end else begin
                    err_nx = 1'b1;
                end
                cnt_nx = '0;
            end else begin
                stb_nx = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge cph1) begin
        if (pon) begin
            shift_r   <= '0;
            bit_cnt   <= '0;
            col_drive <= '0;
            col_valid <= 1'b0;
            load_stb  <= 1'b0;
            frame_err <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            shift_r   <= shift_nx;
            bit_cnt   <= cnt_nx;
            col_drive <= col_nx;
            col_valid <= valid_nx;
            load_stb  <= stb_nx;
            frame_err <= err_nx;
            wd_cnt    <= wd_nx;
        end
    end

endmodule

// File: tb/tb_scd_column_latch.sv
module tb_scd_column_latch;

    localparam int W  = 25;
    localparam int SS = 2;
    // Ticks after load_n is driven low until load_stb is seen: tick 1 is the
    // sampling edge, the pulse lands SS+1 edges later.
    localparam int STB_TICK = SS + 2;

    logic         cph1 = 1'b0;
    logic         pon = 1'b1;
    logic         scd_sdclk = 1'b0, scd_data = 1'b0, scd_load_n = 1'b1, scd_rst_n = 1'b1;
    logic [W-1:0] col_drive, col_drive2;
    logic         col_valid, load_stb, frame_err;
    logic         col_valid2, load_stb2, frame_err2;

    int checks = 0;
    int failures = 0;

    always #5 cph1 = ~cph1;

    scd_column_latch #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT_CYC(65535)) dut (
        .cph1(cph1), .pon(pon), .scd_sdclk(scd_sdclk), .scd_data(scd_data),
        .scd_load_n(scd_load_n), .scd_rst_n(scd_rst_n), .col_drive(col_drive),
        .col_valid(col_valid), .load_stb(load_stb), .frame_err(frame_err));

    // Short-timeout copy for the watchdog scenario; shares all inputs.
    scd_column_latch #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT_CYC(16)) dut_wd (
        .cph1(cph1), .pon(pon), .scd_sdclk(scd_sdclk), .scd_data(scd_data),
        .scd_load_n(scd_load_n), .scd_rst_n(scd_rst_n), .col_drive(col_drive2),
        .col_valid(col_valid2), .load_stb(load_stb2), .frame_err(frame_err2));

    typedef struct {
        int           nbits;
        logic [31:0]  bits;
        logic [W-1:0] exp_col;
        logic         exp_valid;
        logic         exp_err;
        int           exp_stb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cph1);
        #1;
    endtask

    task automatic send_bit(input logic b);
        scd_sdclk = 1'b0;
        scd_data  = b;
        tick(); tick();
        scd_sdclk = 1'b1;
        tick(); tick();
    endtask

    // Send the low n bits of v, most significant first.
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // load_n low for 2 ticks, high for 6; report main-DUT load_stb pulses.
    task automatic pulse_load(output int cnt, output int at);
        cnt = 0;
        at  = 0;
        scd_load_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) scd_load_n = 1'b1;
            tick();
            if (load_stb) begin
                cnt++;
                at = k;
            end
        end
    endtask

    initial begin
        int cnt, at, k;
        logic [W-1:0] fr;
        logic seen;

        vecs[0] = '{25, 32'h01555555, 25'h1555555, 1'b1, 1'b0, 1};
        vecs[1] = '{24, 32'h00ABCDEF, 25'h1555555, 1'b1, 1'b1, 0};
        vecs[2] = '{25, 32'h000F0F0F0, 25'h00F0F0F0, 1'b1, 1'b1, 1};
        vecs[3] = '{0,  32'h00000000, 25'h00F0F0F0, 1'b1, 1'b1, 0};
        vecs[4] = '{26, 32'h03FFFFFF, 25'h00F0F0F0, 1'b1, 1'b1, 0};
        vecs[5] = '{30, 32'h3FFFFFFF, 25'h00F0F0F0, 1'b1, 1'b1, 0};
        vecs[6] = '{25, 32'h01FFFFFF, 25'h1FFFFFF, 1'b1, 1'b1, 1};
        vecs[7] = '{25, 32'h00000001, 25'h0000001, 1'b1, 1'b1, 1};

        // Reset state.
        tick(); tick();
        chk("rst_col", 32'(col_drive), 32'h0);
        chk("rst_valid", 32'(col_valid), 32'h0);
        chk("rst_stb", 32'(load_stb), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        pon = 1'b0;
        tick(); tick();

        // Table-driven frames: good, short, empty, long, saturating.
        for (int v = 0; v < 8; v++) begin
            send_bits(vecs[v].bits, vecs[v].nbits);
            tick(); tick();
            pulse_load(cnt, at);
            chk($sformatf("v%0d_col", v), 32'(col_drive), 32'(vecs[v].exp_col));
            chk($sformatf("v%0d_valid", v), 32'(col_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_err", v), 32'(frame_err), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_stbcnt", v), 32'(cnt), 32'(vecs[v].exp_stb));
            if (vecs[v].exp_stb == 1) chk($sformatf("v%0d_stbtick", v), 32'(at), 32'(STB_TICK));
        end

        // Link reset mid-frame: outputs clear, frame_err survives, clean restart.
        send_bits(32'h2AA, 10);
        scd_rst_n = 1'b0;
        tick(); tick(); tick(); tick();
        chk("lrst_col", 32'(col_drive), 32'h0);
        chk("lrst_valid", 32'(col_valid), 32'h0);
        chk("lrst_err", 32'(frame_err), 32'h1);
        scd_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        send_bits(32'h01234567, 25);
        tick(); tick();
        pulse_load(cnt, at);
        chk("lrst_new_col", 32'(col_drive), 32'h01234567);
        chk("lrst_new_valid", 32'(col_valid), 32'h1);
        chk("lrst_new_stb", 32'(cnt), 32'h1);

        // pon mid-shift with an sdclk rise already inside the synchroniser.
        send_bits(32'h0FFF, 12);
        scd_sdclk = 1'b0;
        tick(); tick();
        scd_sdclk = 1'b1;
        tick();
        pon = 1'b1;
        scd_sdclk = 1'b0;
        tick();
        chk("pon_col", 32'(col_drive), 32'h0);
        chk("pon_valid", 32'(col_valid), 32'h0);
        chk("pon_stb", 32'(load_stb), 32'h0);
        chk("pon_err", 32'(frame_err), 32'h0);
        pon = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Last sdclk rise coincident with load_n fall: a complete 25-bit frame.
        fr = 25'h1C3A5F0;
        send_bits(32'(fr) >> 1, 24);
        scd_sdclk = 1'b0;
        scd_data  = fr[0];
        tick(); tick();
        scd_sdclk = 1'b1;
        pulse_load(cnt, at);
        chk("coin_col", 32'(col_drive), 32'(fr));
        chk("coin_err", 32'(frame_err), 32'h0);
        chk("coin_stbcnt", 32'(cnt), 32'h1);
        chk("coin_stbtick", 32'(at), 32'(STB_TICK));

        // Watchdog on the TIMEOUT_CYC=16 instance.
        send_bits(32'h00000F0F, 25);
        tick(); tick();
        scd_load_n = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            if (i == 3) scd_load_n = 1'b1;
            tick();
            if (load_stb2) seen = 1'b1;
        end
        scd_load_n = 1'b1;
        chk("wd_stb_seen", 32'(seen), 32'h1);
        chk("wd_live_col", 32'(col_drive2), 32'h00000F0F);
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            tick();
            if (!col_valid2) k = i;
        end
        chk("wd_expiry_cycles", 32'(k), 32'd16);
        chk("wd_blank_col", 32'(col_drive2), 32'h0);
        chk("wd_long_still_valid", 32'(col_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
